waveform_sequencer: RTL

Phase-accumulator address sequencer that drives the generator's sample memory. It walks the waveform table at a programmable fractional rate and counts complete periods. It compensates for the memory's one-cycle registered read latency and presents a qualified sample stream to the downstream output stage. It sits between the control/register logic (start, stop, frequency, burst length) and the sample memory's `address`/`sample` ports.

---
 rtl/waveform_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/waveform_sequencer.sv
// Phase-accumulator address sequencer for the waveform sample memory.
// Walks the table at a fractional rate, counts periods and realigns memory read data.
module waveform_sequencer #(
    parameter int ADDR_W     = 12,
    parameter int FRAC_W     = 12,
    parameter int TABLE_SIZE = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [ADDR_W+FRAC_W-1:0] freq_word,
    input  logic [15:0]              n_periods,
    output logic [ADDR_W-1:0]        address,
    output logic                     addr_valid,
    input  logic [ADDR_W-1:0]        sample,
    output logic [ADDR_W-1:0]        sample_out,
    output logic                     sample_valid,
    output logic                     wrap,
    output logic                     busy,
    output logic                     done
);

    localparam int PH_W = ADDR_W + FRAC_W;
    localparam logic [PH_W:0]   SPAN    = (PH_W+1)'(TABLE_SIZE) << FRAC_W;
    localparam logic [PH_W-1:0] SPAN_LO = SPAN[PH_W-1:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [PH_W-1:0]   phase, phase_next;
    logic [PH_W-1:0]   inc, inc_next;
    logic [15:0]       limit, limit_next;
    logic [15:0]       period_cnt, cnt_next;
    logic [ADDR_W-1:0] addr_next;
    logic              av_next, wrap_next, done_next;
    logic              drain_cnt, drain_next;
    logic [PH_W:0]     p_sum;
    logic [PH_W-1:0]   p_wrapped;
    logic              vld_p1;

    always_comb begin
        state_next = state;
        phase_next = phase;
        inc_next   = inc;
        limit_next = limit;
        cnt_next   = period_cnt;
        addr_next  = address;
        av_next    = 1'b0;
        wrap_next  = 1'b0;
        done_next  = 1'b0;
        drain_next = drain_cnt;
        p_sum      = {1'b0, phase} + {1'b0, inc};
        p_wrapped  = p_sum[PH_W-1:0] - SPAN_LO;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = RUN;
                    inc_next   = freq_word;
                    limit_next = n_periods;
                    phase_next = '0;
                    cnt_next   = '0;
                    addr_next  = '0;
                    av_next    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = DRAIN;
                    drain_next = 1'b0;
                end else if (p_sum >= SPAN) begin
                    // New frequency is only taken at a period boundary.
                    cnt_next   = period_cnt + 16'd1;
                    phase_next = p_wrapped;
                    inc_next   = freq_word;
                    if ((limit != 16'd0) && (cnt_next == limit)) begin
                        state_next = DRAIN;
                        drain_next = 1'b0;
                    end else begin
                        addr_next = p_wrapped[PH_W-1:FRAC_W];
                        av_next   = 1'b1;
                        wrap_next = 1'b1;
                    end
                end else begin
                    phase_next = p_sum[PH_W-1:0];
                    addr_next  = p_sum[PH_W-1:FRAC_W];
                    av_next    = 1'b1;
                end
            end
            DRAIN: begin
                // Two cycles covers the memory read plus the output register.
                if (drain_cnt) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    drain_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: address generation and control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= '0;
            period_cnt <= '0;
            address    <= '0;
            addr_valid <= 1'b0;
            wrap       <= 1'b0;
            done       <= 1'b0;
            drain_cnt  <= 1'b0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            period_cnt <= cnt_next;
            address    <= addr_next;
            addr_valid <= av_next;
            wrap       <= wrap_next;
            done       <= done_next;
            drain_cnt  <= drain_next;
        end
    end

    always_ff @(posedge clk) begin
        inc   <= inc_next;
        limit <= limit_next;
    end

    // Stage p1/p2: memory read latency, then output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1       <= 1'b0;
            sample_valid <= 1'b0;
            sample_out   <= '0;
        end else begin
            vld_p1       <= addr_valid;
            sample_valid <= vld_p1;
            if (vld_p1) sample_out <= sample;
        end
    end

    assign busy = (state != IDLE);

endmodule
